// File: rtl/syn_clk_split.sv
// ---------------------------------------------------------------------------
// syn_clk_split
//
// Splits the monotonic 64-bit global sync time into a cycle-relative time,
// a cycle index and a cycle-start pulse. Alignment is done once with a
// 64-step restoring division of the global time by the cycle length. After
// that, a bounded catch-up loop and a per-clock wrap tracker follow the
// incrementing time. In 1588 mode the global time passes straight through.
//
// Ports:
//   i_clk            system clock (125 MHz)
//   i_rst_n          asynchronous active-low reset
//   iv_global_time   64-bit monotonic global sync time in ns
//   i_tsn_or_tte     1 = 1588 passthrough, 0 = 6802 cycle split
//   iv_syn_clk_cycle sync cycle length in ns (< MIN_CYCLE means unconfigured)
//   ov_cycle_time    time within the current cycle
//   ov_cycle_index   cycle count since the alignment base, mod 2^32
//   o_cycle_start    one-clock pulse on the first clock of a new cycle
//   o_time_valid     ov_cycle_time / ov_cycle_index are trustworthy
//   o_resync         one-clock pulse when a jump or cycle change realigns
// ---------------------------------------------------------------------------
module syn_clk_split #(
  parameter int unsigned MIN_CYCLE = 64,
  parameter int unsigned TIME_STEP = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] iv_global_time,
  input  logic        i_tsn_or_tte,
  input  logic [31:0] iv_syn_clk_cycle,
  output logic [31:0] ov_cycle_time,
  output logic [31:0] ov_cycle_index,
  output logic        o_cycle_start,
  output logic        o_time_valid,
  output logic        o_resync
);

  localparam logic [31:0] MIN_CYCLE_W = 32'(MIN_CYCLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_CATCHUP,
    S_TRACK
  } state_e;

  state_e      r_state;
  state_e      w_next_state;

  logic [63:0] r_base;
  logic [63:0] r_t0;
  logic [63:0] r_quot;
  logic [31:0] r_rem;
  logic [6:0]  r_bitcnt;
  logic [31:0] r_cycle;
  logic [31:0] r_index;

  logic [31:0] r_cycle_time;
  logic [31:0] r_cycle_index;
  logic        r_cycle_start;
  logic        r_time_valid;
  logic        r_resync;

  logic        w_cycle_ok;
  logic        w_cycle_chg;
  logic        w_behind;
  logic        w_wrap;
  logic        w_jump;
  logic [63:0] w_delta;
  logic [32:0] w_two_cycle;
  logic [31:0] w_wrap_time;
  logic [32:0] w_rem_shift;
  logic        w_rem_ge;
  logic [31:0] w_rem_diff;
  logic [31:0] w_rem_next;
  logic [63:0] w_quot_next;
  logic        w_div_done;

  logic [31:0] w_nxt_time;
  logic [31:0] w_nxt_index;
  logic        w_nxt_start;
  logic        w_nxt_valid;
  logic        w_nxt_resync;

  // A nominal step at or above the smallest cycle could push delta past
  // 2*cycle in a single clock, making every wrap look like a jump.
  a_step_below_min: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (TIME_STEP < MIN_CYCLE));

  assign w_cycle_ok  = (iv_syn_clk_cycle >= MIN_CYCLE_W);
  assign w_cycle_chg = (r_state != S_IDLE) && (iv_syn_clk_cycle != r_cycle);

  assign w_delta     = iv_global_time - r_base;
  assign w_behind    = (iv_global_time < r_base);
  assign w_two_cycle = {r_cycle, 1'b0};
  assign w_wrap      = (w_delta >= {32'd0, r_cycle});
  assign w_jump      = w_behind || (w_delta >= {31'd0, w_two_cycle});
  // Only used when cycle <= delta < 2*cycle, so the result fits in 32 bits.
  assign w_wrap_time = w_delta[31:0] - r_cycle;

  // Restoring division step: r_quot holds the not-yet-consumed dividend
  // bits at the top and the quotient bits collected so far at the bottom.
  assign w_rem_shift = {r_rem, r_quot[63]};
  assign w_rem_ge    = (w_rem_shift >= {1'b0, r_cycle});
  // The true difference is below cycle, so 32-bit arithmetic is exact.
  assign w_rem_diff  = w_rem_shift[31:0] - r_cycle;
  assign w_rem_next  = w_rem_ge ? w_rem_diff : w_rem_shift[31:0];
  assign w_quot_next = {r_quot[62:0], w_rem_ge};
  assign w_div_done  = (r_bitcnt == 7'd63);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Priority: passthrough > cycle change > jump > normal wrap.
  always_comb begin
    w_next_state = r_state;
    if (i_tsn_or_tte) begin
      w_next_state = S_IDLE;
    end else if (r_state == S_IDLE) begin
      if (w_cycle_ok) begin
        w_next_state = S_DIVIDE;
      end
    end else if (w_cycle_chg) begin
      w_next_state = w_cycle_ok ? S_DIVIDE : S_IDLE;
    end else begin
      case (r_state)
        S_DIVIDE: begin
          if (w_div_done) begin
            w_next_state = S_CATCHUP;
          end
        end
        S_CATCHUP: begin
          if (!w_wrap) begin
            w_next_state = S_TRACK;
          end
        end
        S_TRACK: begin
          if (w_jump) begin
            w_next_state = S_DIVIDE;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs. Time and index hold their last
  // value whenever they are not valid.
  always_comb begin
    w_nxt_time   = r_cycle_time;
    w_nxt_index  = r_cycle_index;
    w_nxt_start  = 1'b0;
    w_nxt_valid  = 1'b0;
    w_nxt_resync = 1'b0;
    if (i_tsn_or_tte) begin
      w_nxt_time  = iv_global_time[31:0];
      w_nxt_index = iv_global_time[63:32];
      w_nxt_valid = 1'b1;
    end else if (r_state == S_IDLE) begin
      w_nxt_valid = 1'b0;
    end else if (w_cycle_chg) begin
      w_nxt_resync = w_cycle_ok;
    end else if (r_state == S_TRACK) begin
      if (w_jump) begin
        w_nxt_resync = 1'b1;
      end else if (w_wrap) begin
        w_nxt_time  = w_wrap_time;
        w_nxt_index = r_index + 32'd1;
        w_nxt_start = 1'b1;
        w_nxt_valid = 1'b1;
      end else begin
        w_nxt_time  = w_delta[31:0];
        w_nxt_index = r_index;
        w_nxt_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_base        <= 64'd0;
      r_t0          <= 64'd0;
      r_quot        <= 64'd0;
      r_rem         <= 32'd0;
      r_bitcnt      <= 7'd0;
      r_cycle       <= 32'd0;
      r_index       <= 32'd0;
      r_cycle_time  <= 32'd0;
      r_cycle_index <= 32'd0;
      r_cycle_start <= 1'b0;
      r_time_valid  <= 1'b0;
      r_resync      <= 1'b0;
    end else begin
      r_cycle_time  <= w_nxt_time;
      r_cycle_index <= w_nxt_index;
      r_cycle_start <= w_nxt_start;
      r_time_valid  <= w_nxt_valid;
      r_resync      <= w_nxt_resync;

      if (i_tsn_or_tte) begin
        r_bitcnt <= 7'd0;
      end else if ((r_state == S_IDLE) || w_cycle_chg) begin
        // Entering or restarting a division; a drop below the minimum
        // leaves everything as is since IDLE relatches on the way out.
        if (w_cycle_ok) begin
          r_cycle  <= iv_syn_clk_cycle;
          r_t0     <= iv_global_time;
          r_quot   <= iv_global_time;
          r_rem    <= 32'd0;
          r_bitcnt <= 7'd0;
        end
      end else begin
        case (r_state)
          S_DIVIDE: begin
            r_quot   <= w_quot_next;
            r_rem    <= w_rem_next;
            r_bitcnt <= r_bitcnt + 7'd1;
            if (w_div_done) begin
              r_base  <= r_t0 - {32'd0, w_rem_next};
              r_index <= w_quot_next[31:0];
            end
          end
          S_CATCHUP: begin
            if (w_wrap) begin
              r_base  <= r_base + {32'd0, r_cycle};
              r_index <= r_index + 32'd1;
            end
          end
          S_TRACK: begin
            if (w_jump) begin
              r_t0     <= iv_global_time;
              r_quot   <= iv_global_time;
              r_rem    <= 32'd0;
              r_bitcnt <= 7'd0;
            end else if (w_wrap) begin
              r_base  <= r_base + {32'd0, r_cycle};
              r_index <= r_index + 32'd1;
            end
          end
          default: begin
            r_bitcnt <= 7'd0;
          end
        endcase
      end
    end
  end

  assign ov_cycle_time  = r_cycle_time;
  assign ov_cycle_index = r_cycle_index;
  assign o_cycle_start  = r_cycle_start;
  assign o_time_valid   = r_time_valid;
  assign o_resync       = r_resync;

endmodule

// File: tb/tb_syn_clk_split.sv
// ---------------------------------------------------------------------------
// tb_syn_clk_split
//
// Directed bench for syn_clk_split. The global time is stepped by the bench;
// expected cycle time and index come from plain division of that time by the
// configured cycle (time = g mod C, index = (g / C) mod 2^32).
// ---------------------------------------------------------------------------
module tb_syn_clk_split;

  logic        i_clk;
  logic        i_rst_n;
  logic [63:0] iv_global_time;
  logic        i_tsn_or_tte;
  logic [31:0] iv_syn_clk_cycle;
  logic [31:0] ov_cycle_time;
  logic [31:0] ov_cycle_index;
  logic        o_cycle_start;
  logic        o_time_valid;
  logic        o_resync;

  longint unsigned gTime;
  logic [31:0]     cyc;
  logic            tsn;
  int              nCompared;
  int              nMismatched;

  syn_clk_split #(
    .MIN_CYCLE(64),
    .TIME_STEP(8)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .iv_global_time  (iv_global_time),
    .i_tsn_or_tte    (i_tsn_or_tte),
    .iv_syn_clk_cycle(iv_syn_clk_cycle),
    .ov_cycle_time   (ov_cycle_time),
    .ov_cycle_index  (ov_cycle_index),
    .o_cycle_start   (o_cycle_start),
    .o_time_valid    (o_time_valid),
    .o_resync        (o_resync)
  );

  // 125 MHz system clock
  initial i_clk = 1'b0;
  always #4 i_clk = ~i_clk;

  // Hard stop in case something hangs despite the bounded waits
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] expTime(input longint unsigned g, input logic [31:0] c);
    return 32'(g % 64'(c));
  endfunction

  function automatic logic [31:0] expIndex(input longint unsigned g, input logic [31:0] c);
    return 32'(g / 64'(c));
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the bench inputs, clock once, and return 1 ns after the edge
  task automatic applyStimulus();
    iv_global_time   = gTime;
    iv_syn_clk_cycle = cyc;
    i_tsn_or_tte     = tsn;
    @(posedge i_clk);
    #1;
  endtask

  task automatic doReset();
    i_rst_n = 1'b0;
    tsn     = 1'b0;
    iv_global_time   = gTime;
    iv_syn_clk_cycle = cyc;
    i_tsn_or_tte     = tsn;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  // Step time until valid rises; no cycle_start or resync expected meanwhile
  task automatic waitValid(input int bound, input longint unsigned step, output int n);
    bit sawStart;
    bit sawResync;
    sawStart  = 1'b0;
    sawResync = 1'b0;
    n = 0;
    do begin
      gTime += step;
      applyStimulus();
      if (!o_time_valid) begin
        sawStart  = sawStart | o_cycle_start;
        sawResync = sawResync | o_resync;
      end
      n++;
    end while (!o_time_valid && n < bound);
    checkOutput("alignDone", o_time_valid, 1);
    checkOutput("alignNoStart", sawStart, 0);
    checkOutput("alignNoResync", sawResync, 0);
    checkOutput("alignTime", ov_cycle_time, expTime(gTime, cyc));
    checkOutput("alignIndex", ov_cycle_index, expIndex(gTime, cyc));
  endtask

  task automatic trackRun(input int n);
    longint unsigned prev;
    for (int i = 0; i < n; i++) begin
      prev = gTime;
      gTime += 8;
      applyStimulus();
      checkOutput("trackValid", o_time_valid, 1);
      checkOutput("trackTime", ov_cycle_time, expTime(gTime, cyc));
      checkOutput("trackIndex", ov_cycle_index, expIndex(gTime, cyc));
      checkOutput("trackStart", o_cycle_start,
                  (expIndex(prev, cyc) != expIndex(gTime, cyc)) ? 1 : 0);
      checkOutput("trackResync", o_resync, 0);
    end
  endtask

  initial begin
    int n;
    logic [31:0] idxBefore;
    nCompared   = 0;
    nMismatched = 0;
    gTime = 0;
    cyc   = 32'd1000;
    tsn   = 1'b0;

    // Reset state
    doReset();
    checkOutput("rstTime", ov_cycle_time, 0);
    checkOutput("rstIndex", ov_cycle_index, 0);
    checkOutput("rstStart", o_cycle_start, 0);
    checkOutput("rstValid", o_time_valid, 0);
    checkOutput("rstResync", o_resync, 0);

    // Basic alignment from time 0, then tracking across 1000/2000/...
    $display("[TB] basic alignment, cycle 1000");
    waitValid(200, 8, n);
    checkOutput("basicSpan", (n >= 65) ? 1 : 0, 1);
    trackRun(300);

    // Backward jump of -24 while cycle time is 8
    $display("[TB] backward jump");
    for (int k = 0; k < 200 && ov_cycle_time != 32'd8; k++) begin
      trackRun(1);
    end
    checkOutput("bwdPreTime", ov_cycle_time, 8);
    idxBefore = ov_cycle_index;
    gTime -= 24;
    applyStimulus();
    checkOutput("bwdResync", o_resync, 1);
    checkOutput("bwdInvalid", o_time_valid, 0);
    waitValid(200, 0, n);
    checkOutput("bwdTime", ov_cycle_time, 984);
    checkOutput("bwdIndex", ov_cycle_index, idxBefore - 32'd1);
    trackRun(20);

    // Forward jump of +5000
    $display("[TB] forward jump");
    gTime += 5000;
    applyStimulus();
    checkOutput("fwdResync", o_resync, 1);
    checkOutput("fwdInvalid", o_time_valid, 0);
    waitValid(200, 8, n);
    checkOutput("fwdSpan", (n >= 65) ? 1 : 0, 1);
    trackRun(150);

    // Asynchronous reset in the middle of tracking acts without a clock
    $display("[TB] async reset");
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("asyncValid", o_time_valid, 0);
    checkOutput("asyncTime", ov_cycle_time, 0);
    checkOutput("asyncIndex", ov_cycle_index, 0);

    // Large start value exercises the 64-bit divider
    $display("[TB] large start time");
    gTime = 64'd10_000_003_000;
    doReset();
    waitValid(200, 8, n);
    checkOutput("bigIndex", ov_cycle_index, 32'd10_000_003);
    trackRun(50);

    // Index wrap 0xFFFFFFFF -> 0
    $display("[TB] index wrap");
    gTime = 64'd4294967295000 - 64'd8;
    doReset();
    waitValid(200, 8, n);
    checkOutput("wrapPreIndex", ov_cycle_index, 32'hFFFF_FFFF);
    trackRun(100);
    checkOutput("wrapPostIndex", ov_cycle_index, 0);

    // Passthrough wins over everything, then returns via IDLE/DIVIDE
    $display("[TB] passthrough");
    tsn   = 1'b1;
    gTime = 64'h0000_0005_0000_1234;
    applyStimulus();
    checkOutput("ptTime", ov_cycle_time, 32'h0000_1234);
    checkOutput("ptIndex", ov_cycle_index, 5);
    checkOutput("ptValid", o_time_valid, 1);
    checkOutput("ptStart", o_cycle_start, 0);
    checkOutput("ptResync", o_resync, 0);
    gTime += 8;
    applyStimulus();
    checkOutput("ptTime2", ov_cycle_time, 32'h0000_123C);
    tsn = 1'b0;
    gTime += 8;
    applyStimulus();
    checkOutput("ptExitValid", o_time_valid, 0);
    checkOutput("ptExitResync", o_resync, 0);
    waitValid(200, 8, n);
    checkOutput("ptExitSpan", (n >= 65) ? 1 : 0, 1);
    trackRun(20);

    // Cycle change 1000 -> 500 in the middle of a division
    $display("[TB] cycle change mid-divide");
    gTime = 64'd100000;
    cyc   = 32'd1000;
    doReset();
    for (int k = 0; k < 20; k++) begin
      gTime += 8;
      applyStimulus();
    end
    checkOutput("chgPreValid", o_time_valid, 0);
    cyc = 32'd500;
    gTime += 8;
    applyStimulus();
    checkOutput("chgResync", o_resync, 1);
    checkOutput("chgValid", o_time_valid, 0);
    waitValid(200, 8, n);
    checkOutput("chgSpan", (n >= 65) ? 1 : 0, 1);
    trackRun(150);

    // Cycle below minimum drops back to IDLE
    cyc = 32'd0;
    gTime += 8;
    applyStimulus();
    checkOutput("zeroValid", o_time_valid, 0);
    checkOutput("zeroResync", o_resync, 0);
    for (int k = 0; k < 5; k++) begin
      gTime += 8;
      applyStimulus();
    end
    checkOutput("zeroIdleValid", o_time_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
